// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall vectors, exception codes and controller states
package pipe_ctrl_pkg;

  localparam logic [5:0]  StallMem  = 6'b011111;
  localparam logic [5:0]  StallEx   = 6'b001111;
  localparam logic [5:0]  StallId   = 6'b000111;
  localparam logic [5:0]  StallNone = 6'b000000;

  localparam logic [31:0] ExcEret   = 32'h0000_000E;

  typedef enum logic [1:0] {
    CtrlRun     = 2'd0,
    CtrlStalled = 2'd1,
    CtrlShadow  = 2'd2
  } ctrl_state_e;

  // The deepest requesting stage wins: freezing it freezes everything upstream.
  function automatic logic [5:0] stall_vec(input logic id, input logic ex, input logic mem);
    if (mem)     return StallMem;
    else if (ex) return StallEx;
    else if (id) return StallId;
    else         return StallNone;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// rtl/pipe_ctrl_stall_watchdog.sv - stall run-length watchdog and saturating stall-cycle counter
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stalled,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic                 stall_timeout_o
);

  localparam int RunW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STALL_TIMEOUT);

  logic [RunW-1:0]      run_len_q, run_len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  always_comb begin
    run_len_d = run_len_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q | (run_len_q == RunMax);
    if (clear)
      run_len_d = '0;
    else if (stalled && run_len_q != RunMax)
      run_len_d = run_len_q + RunW'(1);
    if (stalled && cnt_q != {CNT_WIDTH{1'b1}})
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_len_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_len_q <= run_len_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles_o  = cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, exception/ERET flush sequencing and stall watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          STALL_TIMEOUT = 1023,
  parameter int          CNT_WIDTH     = 32,
  parameter logic [31:0] EXC_VEC       = 32'h0000_0020
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id_i,
  input  logic                 stallreq_ex_i,
  input  logic                 stallreq_mem_i,
  input  logic [31:0]          excepttype_i,
  input  logic [31:0]          cp0_epc_i,
  output logic [5:0]           stall_o,
  output logic                 flush_o,
  output logic [31:0]          new_pc_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic                 stall_timeout_o
);

  ctrl_state_e state_q, state_d;

  // Outputs are combinational so a stage freezes in the same cycle it asks.
  always_comb begin
    stall_o  = StallNone;
    flush_o  = 1'b0;
    new_pc_o = '0;
    state_d  = CtrlRun;
    if (rst) begin
      state_d = CtrlRun;
    end else if (excepttype_i != '0 && state_q != CtrlShadow) begin
      flush_o  = 1'b1;
      new_pc_o = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VEC;
      state_d  = CtrlShadow;
    end else begin
      stall_o = stall_vec(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
      state_d = (stall_o != StallNone) ? CtrlStalled : CtrlRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= CtrlRun;
    else     state_q <= state_d;
  end

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_watchdog (
    .clk             (clk),
    .rst             (rst),
    .stalled         (stall_o != StallNone),
    .clear           ((stall_o == StallNone) || flush_o),
    .stall_cycles_o  (stall_cycles_o),
    .stall_timeout_o (stall_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;

  localparam int          T   = 4;
  localparam int          CW  = 6;
  localparam logic [31:0] EXC = 32'h0000_0020;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_r = 1'b1, ex_r = 1'b1, mem_r = 1'b1;
  logic [31:0]   et = 32'h0000_000E, epc = '0;
  logic [5:0]    stall_o;
  logic          flush_o;
  logic [31:0]   new_pc_o;
  logic [CW-1:0] stall_cycles_o;
  logic          stall_timeout_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(T), .CNT_WIDTH(CW), .EXC_VEC(EXC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id_i   (id_r),
    .stallreq_ex_i   (ex_r),
    .stallreq_mem_i  (mem_r),
    .excepttype_i    (et),
    .cp0_epc_i       (epc),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .stall_cycles_o  (stall_cycles_o),
    .stall_timeout_o (stall_timeout_o)
  );

  typedef struct {
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   pc;
    logic [CW-1:0] cyc;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit   m_shadow = 0;
  int   m_run = 0;
  int   m_cyc = 0;
  bit   m_to = 0;

  task automatic apply(input bit r, input bit id, input bit ex, input bit mem,
                       input logic [31:0] t, input logic [31:0] pc);
    exp_t e;
    bit   exc;
    @(posedge clk);
    #1;
    rst = r; id_r = id; ex_r = ex; mem_r = mem; et = t; epc = pc;
    exc     = !r && (t != 0) && !m_shadow;
    e.flush = exc;
    e.pc    = exc ? ((t == 32'h0000_000E) ? pc : EXC) : 32'h0;
    e.stall = (r || exc) ? 6'd0 : mem ? 6'h1F : ex ? 6'h0F : id ? 6'h07 : 6'd0;
    e.cyc   = CW'(m_cyc);
    e.to    = m_to;
    sb.push_back(e);
    if (r) begin
      m_shadow = 0; m_run = 0; m_cyc = 0; m_to = 0;
    end else begin
      if (m_run == T) m_to = 1;
      m_run = (e.stall != 0) ? ((m_run < T) ? m_run + 1 : T) : 0;
      if (e.stall != 0 && m_cyc < (1 << CW) - 1) m_cyc++;
      m_shadow = exc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %h want %h", name, vectors, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      check("stall_o", 32'(stall_o), 32'(e.stall));
      check("flush_o", 32'(flush_o), 32'(e.flush));
      check("new_pc_o", new_pc_o, e.pc);
      check("stall_cycles_o", 32'(stall_cycles_o), 32'(e.cyc));
      check("stall_timeout_o", 32'(stall_timeout_o), 32'(e.to));
    end
  end

  initial begin
    logic [31:0] t;
    repeat (2) apply(1, 1, 1, 1, 32'h0000_000E, 32'h1234_5678);
    repeat (3) apply(0, 1, 0, 0, 0, 0);
    repeat (2) apply(0, 0, 0, 0, 0, 0);
    repeat (2) apply(0, 1, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 32'h1, 0);
    apply(0, 0, 0, 1, 32'h8, 0);
    apply(0, 0, 0, 0, 32'h8, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 32'h0000_000E, 32'h8000_0100);
    repeat (2) apply(0, 0, 0, 0, 0, 32'h8000_0100);
    repeat (6) apply(0, 0, 0, 1, 0, 0);
    repeat (3) apply(0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    repeat (2) apply(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      t = 0;
      if ($urandom_range(0, 9) == 0)
        t = ($urandom_range(0, 1) == 0) ? 32'h0000_000E : ($urandom | 32'h1);
      apply($urandom_range(0, 149) == 0, $urandom_range(0, 4) < 2, $urandom_range(0, 4) < 2,
            $urandom_range(0, 4) < 2, t, $urandom);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
